// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - ALU operand/control issuer with shift-add MULSA macro op
//
// Purpose: accepts an operation request, drives the combinational ALU, captures
// its result and returns it as a response. Single ALU codes take one issue
// cycle. MULSA (code 13) builds the low 32 bits of an unsigned product by
// repeated ALU ADDs.
//
// Build option: define MUL_EARLY_EXIT_EN to end MULSA iteration as soon as the
// remaining multiplier bits are all zero.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i/req_ready_o       request handshake; op_i, a_i, b_i payload
//   resp_valid_o/resp_ready_i     response handshake; result_o, zero_o, err_o
//   busy_o                        block is not idle
//   alu_src1_o/alu_src2_o/alu_ctrl_o  operands and control to the ALU
//   alu_result_i/alu_zero_i       ALU result and zero flag

module alu_op_issuer #(
  parameter int WIDTH     = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i
);

  localparam int         CNT_W    = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_MULSA = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ITER, S_RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [CNT_W-1:0] cnt;

  logic             is_single;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mc_next;
  logic [WIDTH-1:0] mp_next;
  logic             iter_done;

  always_comb begin
    is_single = 1'b0;
    case (op_i)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd11, 4'd12: is_single = 1'b1;
      default:                                    is_single = 1'b0;
    endcase
  end

  // The ALU is adding ACC + MC this cycle; keep the sum only when the
  // current multiplier bit is set.
  always_comb begin
    acc_next = mp[0] ? alu_result_i : acc;
    mc_next  = mc << 1;
    mp_next  = mp >> 1;
`ifdef MUL_EARLY_EXIT_EN
    iter_done = (cnt == CNT_W'(MUL_ITERS - 1)) || (mp_next == '0);
`else
    iter_done = (cnt == CNT_W'(MUL_ITERS - 1));
`endif
  end

  assign req_ready_o = (state == S_IDLE) && !rst_i;
  assign busy_o      = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      result_o     <= '0;
      zero_o       <= 1'b0;
      err_o        <= 1'b0;
      resp_valid_o <= 1'b0;
      alu_src1_o   <= '0;
      alu_src2_o   <= '0;
      alu_ctrl_o   <= '0;
      acc          <= '0;
      mc           <= '0;
      mp           <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            if (is_single) begin
              // The ALU port registers double as the latched request.
              state      <= S_ISSUE;
              alu_src1_o <= a_i;
              alu_src2_o <= b_i;
              alu_ctrl_o <= op_i;
            end else if (op_i == OP_MULSA) begin
              state      <= S_ITER;
              acc        <= '0;
              mc         <= a_i;
              mp         <= b_i;
              cnt        <= '0;
              alu_src1_o <= '0;
              alu_src2_o <= a_i;
              alu_ctrl_o <= OP_ADD;
            end else begin
              // Illegal code: answer immediately, never touch the ALU.
              state        <= S_RESP;
              result_o     <= '0;
              zero_o       <= 1'b1;
              err_o        <= 1'b1;
              resp_valid_o <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          state        <= S_RESP;
          result_o     <= alu_result_i;
          zero_o       <= alu_zero_i;
          err_o        <= 1'b0;
          resp_valid_o <= 1'b1;
          alu_src1_o   <= '0;
          alu_src2_o   <= '0;
          alu_ctrl_o   <= '0;
        end

        S_ITER: begin
          acc <= acc_next;
          mc  <= mc_next;
          mp  <= mp_next;
          cnt <= cnt + 1'b1;
          if (iter_done) begin
            state        <= S_RESP;
            result_o     <= acc_next;
            zero_o       <= (acc_next == '0);
            err_o        <= 1'b0;
            resp_valid_o <= 1'b1;
            alu_src1_o   <= '0;
            alu_src2_o   <= '0;
            alu_ctrl_o   <= '0;
          end else begin
            alu_src1_o <= acc_next;
            alu_src2_o <= mc_next;
          end
        end

        S_RESP: begin
          if (resp_ready_i) begin
            state        <= S_IDLE;
            resp_valid_o <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
